// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C request arbiters: FSM state encoding, word width,
// ACK polarity and the audio codec / video decoder slave addresses.
package i2c_pkg;

    localparam int I2C_WORD_W = 24;

    // The controller's ACK line is high when the slave did not acknowledge
    localparam logic I2C_NACK = 1'b1;

    localparam logic [7:0] I2C_CODEC_ADDR   = 8'h34;
    localparam logic [7:0] I2C_DECODER_ADDR = 8'h40;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_GAP,
        ST_DONE
    } arb_state_e;

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Requester and controller-side signal bundle for i2c_req_arbiter.
// The slave modport is the arbiter view; master is the requesters plus controller.
interface i2c_req_arbiter_if import i2c_pkg::*; #(parameter int NREQ = 3);

    logic [NREQ-1:0]            iREQ;
    logic [I2C_WORD_W*NREQ-1:0] iDATA;
    logic [NREQ-1:0]            oGNT;
    logic [NREQ-1:0]            oDONE;
    logic [NREQ-1:0]            oERR;
    logic                       oBUSY;
    logic [I2C_WORD_W-1:0]      oI2C_DATA;
    logic                       oI2C_GO;
    logic                       iI2C_END;
    logic                       iI2C_ACK;

    modport slave (
        input  iREQ, iDATA, iI2C_END, iI2C_ACK,
        output oGNT, oDONE, oERR, oBUSY, oI2C_DATA, oI2C_GO
    );

    modport master (
        output iREQ, iDATA, iI2C_END, iI2C_ACK,
        input  oGNT, oDONE, oERR, oBUSY, oI2C_DATA, oI2C_GO
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant for the first set request
// found scanning upward from ptr_i, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ  = 3,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o
);

    int   idx;
    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_i[idx[PTR_W-1:0]]) begin
                gnt_o[idx[PTR_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C_Controller among NREQ register-write requesters,
// with NACK retry and an optional per-attempt watchdog (macro I2C_ARB_TIMEOUT_EN).
module i2c_req_arbiter import i2c_pkg::*; #(
    parameter int NREQ        = 3,
    parameter int MAX_RETRY   = 3,
    parameter int GAP_CYC     = 10240,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    i2c_req_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int RC_W  = $clog2(MAX_RETRY) + 1;
    localparam int GAP_W = $clog2(GAP_CYC) + 1;

    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NREQ - 1);
    localparam logic [RC_W-1:0]  RETRY_MAX = RC_W'(MAX_RETRY);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);

    arb_state_e            state_q;
    logic [PTR_W-1:0]      ptr_q;
    logic [PTR_W-1:0]      sel_q;
    logic [RC_W-1:0]       retry_cnt_q;
    logic                  retry_q;
    logic                  res_err_q;
    logic [GAP_W-1:0]      gap_q;
    logic [1:0]            end_sync_q;
    logic [1:0]            ack_sync_q;
    logic [NREQ-1:0]       gnt_q;
    logic [NREQ-1:0]       done_q;
    logic [NREQ-1:0]       err_q;
    logic                  busy_q;
    logic                  go_q;
    logic [I2C_WORD_W-1:0] data_q;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wdog_q;
`endif

    logic                  end_s;
    logic                  ack_s;
    logic [NREQ-1:0]       pick_oh;
    logic [PTR_W-1:0]      pick_idx;
    logic [I2C_WORD_W-1:0] pick_data;

    assign end_s = end_sync_q[1];
    assign ack_s = ack_sync_q[1];

    rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
        .req_i (bus.iREQ),
        .ptr_i (ptr_q),
        .gnt_o (pick_oh)
    );

    always_comb begin
        pick_idx  = '0;
        pick_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_oh[k]) begin
                pick_idx  = PTR_W'(k);
                pick_data = bus.iDATA[I2C_WORD_W*k +: I2C_WORD_W];
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            retry_cnt_q <= '0;
            retry_q     <= 1'b0;
            res_err_q   <= 1'b0;
            gap_q       <= '0;
            end_sync_q  <= '0;
            ack_sync_q  <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            busy_q      <= 1'b0;
            go_q        <= 1'b0;
            data_q      <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            wdog_q      <= '0;
`endif
        end else begin
            // END/ACK arrive from the controller clock domain
            end_sync_q <= {end_sync_q[0], bus.iI2C_END};
            ack_sync_q <= {ack_sync_q[0], bus.iI2C_ACK};
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|bus.iREQ) begin
                        gnt_q       <= pick_oh;
                        sel_q       <= pick_idx;
                        data_q      <= pick_data;
                        retry_cnt_q <= '0;
                        retry_q     <= 1'b0;
                        res_err_q   <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_START;
                    end
                end
                ST_START: begin
                    go_q    <= 1'b1;
                    retry_q <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
                    wdog_q  <= '0;
`endif
                    state_q <= ST_WAIT_LO;
                end
                ST_WAIT_LO: begin
                    if (!end_s) begin
                        state_q <= ST_WAIT_HI;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    if (wdog_q == WD_LAST) begin
                        go_q      <= 1'b0;
                        res_err_q <= 1'b1;
                        gap_q     <= '0;
                        state_q   <= ST_GAP;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
`endif
                end
                ST_WAIT_HI: begin
                    if (end_s) begin
                        go_q    <= 1'b0;
                        gap_q   <= '0;
                        state_q <= ST_GAP;
                        if (ack_s != I2C_NACK) begin
                            res_err_q <= 1'b0;
                        end else if (retry_cnt_q < RETRY_MAX) begin
                            retry_cnt_q <= retry_cnt_q + 1'b1;
                            retry_q     <= 1'b1;
                        end else begin
                            res_err_q <= 1'b1;
                        end
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (wdog_q == WD_LAST) begin
                        go_q      <= 1'b0;
                        res_err_q <= 1'b1;
                        gap_q     <= '0;
                        state_q   <= ST_GAP;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
`endif
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= retry_q ? ST_START : ST_DONE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= NREQ'(1) << sel_q;
                    err_q   <= res_err_q ? (NREQ'(1) << sel_q) : '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.oGNT      = gnt_q;
    assign bus.oDONE     = done_q;
    assign bus.oERR      = err_q;
    assign bus.oBUSY     = busy_q;
    assign bus.oI2C_GO   = go_q;
    assign bus.oI2C_DATA = data_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: table of single-transfer vectors against a small
// I2C controller model, plus hand-written reset, fairness and timeout sequences.
module tb_i2c_req_arbiter;

    localparam int NREQ    = 3;
    localparam int GAP     = 16;
    localparam int TIMEOUT = 1000;
    localparam logic [23:0] D0 = 24'h34001A;
    localparam logic [23:0] D1 = 24'h400C55;
    localparam logic [23:0] D2 = 24'h340A7F;

    logic iCLK   = 1'b0;
    logic iRST_N = 1'b0;

    i2c_req_arbiter_if #(.NREQ(NREQ)) bus ();

    i2c_req_arbiter #(
        .NREQ(NREQ), .MAX_RETRY(3), .GAP_CYC(GAP), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .bus    (bus)
    );

    always #5 iCLK = ~iCLK;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- controller model ----------------
    int nack_first  = 0;
    bit always_nack = 1'b0;
    bit stuck_end   = 1'b0;
    int m_st  = 0;
    int m_cnt = 0;
    int m_att = 0;

    always @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bus.iI2C_END <= 1'b1;
            bus.iI2C_ACK <= 1'b0;
            m_st  <= 0;
            m_cnt <= 0;
            m_att <= 0;
        end else begin
            if (bus.oGNT != '0) m_att <= 0;
            case (m_st)
                0: if (bus.oI2C_GO && !stuck_end) begin
                    bus.iI2C_END <= 1'b0;
                    m_cnt <= 0;
                    m_st  <= 1;
                end
                1: if (m_cnt == 7) begin
                    bus.iI2C_END <= 1'b1;
                    bus.iI2C_ACK <= always_nack || (m_att < nack_first);
                    m_att <= m_att + 1;
                    m_st  <= 2;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
                default: if (!bus.oI2C_GO) m_st <= 0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    int cyc = 0, end_rise_cyc = 0, last_done_cyc = 0;
    int gnt_n = 0, done_n = 0, go_rises = 0, rises_since_gnt = 0;
    int gap_min = 99999, go_lo_run = 0, go_hi_run = 0, go_hi_last = 0, done_lat = 0;
    int gnt_log [0:63];
    int gnt_sep [0:63];
    logic end_prev = 1'b1;
    logic go_prev  = 1'b0;

    always @(negedge iCLK) begin
        cyc = cyc + 1;
        if (bus.iI2C_END === 1'b1 && end_prev !== 1'b1) end_rise_cyc = cyc;
        end_prev = bus.iI2C_END;
        if (bus.oGNT != '0 && gnt_n < 64) begin
            for (int k = 0; k < NREQ; k++) if (bus.oGNT[k]) gnt_log[gnt_n] = k;
            gnt_sep[gnt_n] = cyc - last_done_cyc;
            gnt_n++;
            rises_since_gnt = 0;
            gap_min = 99999;
        end
        if (bus.oI2C_GO && !go_prev) begin
            go_rises++;
            if (rises_since_gnt > 0 && go_lo_run < gap_min) gap_min = go_lo_run;
            rises_since_gnt++;
            go_hi_run = 0;
        end
        if (!bus.oI2C_GO && go_prev) begin
            go_hi_last = go_hi_run;
            go_lo_run  = 0;
        end
        if (bus.oI2C_GO) go_hi_run++; else go_lo_run++;
        go_prev = bus.oI2C_GO;
        if (bus.oDONE != '0) begin
            done_n++;
            done_lat      = cyc - end_rise_cyc;
            last_done_cyc = cyc;
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic [2:0]  req;
        int          nack;
        bit          alw;
        logic [2:0]  exp_gnt;
        logic [23:0] exp_data;
        int          exp_go;
        bit          exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic wait_gnt(input string tag, output logic [2:0] g, output bit ok);
        ok = 1'b0;
        g  = '0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge iCLK);
            if (bus.oGNT != '0) begin
                ok = 1'b1;
                g  = bus.oGNT;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_gnt_timeout: got no oGNT, expected a grant", tag);
        end
    endtask

    task automatic wait_done(input string tag, input int lim, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < lim && !ok; c++) begin
            @(negedge iCLK);
            if (bus.oDONE != '0) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_done_timeout: got no oDONE, expected one", tag);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [2:0] g;
        bit ok;
        int base_go;
        base_go     = go_rises;
        nack_first  = v.nack;
        always_nack = v.alw;
        bus.iDATA   = {D2, D1, D0};
        bus.iREQ    = v.req;
        wait_gnt(tag, g, ok);
        bus.iREQ = '0;
        if (!ok) return;
        chk({tag, "_gnt"}, int'(g), int'(v.exp_gnt));
        chk({tag, "_busy"}, int'(bus.oBUSY), 1);
        chk({tag, "_data"}, int'(bus.oI2C_DATA), int'(v.exp_data));
        bus.iDATA = '0;
        wait_done(tag, 1000, ok);
        if (!ok) return;
        chk({tag, "_done"}, int'(bus.oDONE), int'(v.exp_gnt));
        chk({tag, "_err"}, int'(bus.oERR), v.exp_err ? int'(v.exp_gnt) : 0);
        chk({tag, "_busy_at_done"}, int'(bus.oBUSY), 0);
        repeat (3) @(negedge iCLK);
        chk({tag, "_go_pulses"}, go_rises - base_go, v.exp_go);
        chk({tag, "_done_latency"}, done_lat, GAP + 4);
        if (v.exp_go > 1) chk({tag, "_gap_ok"}, int'(gap_min >= GAP), 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no end of test, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [2:0] g;
        bit ok;
        int base_gnt, base_done;

        vecs[0] = '{3'b001, 0, 1'b0, 3'b001, D0, 1, 1'b0};
        vecs[1] = '{3'b101, 2, 1'b0, 3'b100, D2, 3, 1'b0};
        vecs[2] = '{3'b011, 0, 1'b1, 3'b001, D0, 4, 1'b1};
        vecs[3] = '{3'b011, 1, 1'b0, 3'b010, D1, 2, 1'b0};
        vecs[4] = '{3'b001, 0, 1'b0, 3'b001, D0, 1, 1'b0};
        vecs[5] = '{3'b110, 0, 1'b0, 3'b010, D1, 1, 1'b0};

        bus.iREQ  = '0;
        bus.iDATA = '0;
        repeat (5) @(negedge iCLK);
        chk("rst_gnt",  int'(bus.oGNT), 0);
        chk("rst_done", int'(bus.oDONE), 0);
        chk("rst_err",  int'(bus.oERR), 0);
        chk("rst_busy", int'(bus.oBUSY), 0);
        chk("rst_go",   int'(bus.oI2C_GO), 0);
        chk("rst_data", int'(bus.oI2C_DATA), 0);
        iRST_N = 1'b1;
        repeat (3) @(negedge iCLK);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // all three requesting from reset: grant latency, then order 0,1,2,0
        nack_first  = 0;
        always_nack = 1'b0;
        iRST_N = 1'b0;
        bus.iREQ  = 3'b111;
        bus.iDATA = {D2, D1, D0};
        repeat (3) @(negedge iCLK);
        base_gnt  = gnt_n;
        base_done = done_n;
        iRST_N = 1'b1;
        @(negedge iCLK);
        chk("hold_gnt_t1",  int'(bus.oGNT), 1);
        chk("hold_busy_t1", int'(bus.oBUSY), 1);
        chk("hold_go_t1",   int'(bus.oI2C_GO), 0);
        @(negedge iCLK);
        chk("hold_go_t2",   int'(bus.oI2C_GO), 1);
        for (int c = 0; c < 600 && gnt_n < base_gnt + 4; c++) @(negedge iCLK);
        bus.iREQ = '0;
        for (int c = 0; c < 300 && done_n < base_done + 4; c++) @(negedge iCLK);
        chk("hold_done_count", done_n - base_done, 4);
        chk("hold_order0", gnt_log[base_gnt],     0);
        chk("hold_order1", gnt_log[base_gnt + 1], 1);
        chk("hold_order2", gnt_log[base_gnt + 2], 2);
        chk("hold_order3", gnt_log[base_gnt + 3], 0);
        for (int k = 1; k < 4; k++)
            chk($sformatf("hold_sep%0d", k), int'(gnt_sep[base_gnt + k] >= 1), 1);
        repeat (3) @(negedge iCLK);

        // reset while waiting for END high, then a fresh request
        bus.iREQ  = 3'b010;
        bus.iDATA = {D2, D1, D0};
        wait_gnt("midrst", g, ok);
        bus.iREQ = '0;
        for (int c = 0; c < 50 && bus.iI2C_END !== 1'b0; c++) @(negedge iCLK);
        repeat (3) @(negedge iCLK);
        base_done = done_n;
        #2 iRST_N = 1'b0;
        #1;
        chk("midrst_go",   int'(bus.oI2C_GO), 0);
        chk("midrst_busy", int'(bus.oBUSY), 0);
        chk("midrst_data", int'(bus.oI2C_DATA), 0);
        chk("midrst_gnt",  int'(bus.oGNT), 0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (40) @(negedge iCLK);
        chk("midrst_no_done", done_n - base_done, 0);
        run_vec('{3'b010, 0, 1'b0, 3'b010, D1, 1, 1'b0}, "postrst");

`ifdef I2C_ARB_TIMEOUT_EN
        begin
            int base_go;
            stuck_end = 1'b1;
            base_go   = go_rises;
            bus.iREQ  = 3'b001;
            bus.iDATA = {D2, D1, D0};
            wait_gnt("tmo", g, ok);
            bus.iREQ = '0;
            wait_done("tmo", 2000, ok);
            if (ok) begin
                chk("tmo_done", int'(bus.oDONE), 1);
                chk("tmo_err",  int'(bus.oERR), 1);
                repeat (3) @(negedge iCLK);
                chk("tmo_go_pulses", go_rises - base_go, 1);
                chk("tmo_go_high",   go_hi_last, TIMEOUT);
            end
            stuck_end = 1'b0;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
